// File: rtl/fetch_unit.sv
// RV32I fetch: owns the PC, issues word requests, buffers returned words in order toward decode.
// Latency: a request accepted in cycle N with a 1-cycle memory is presented to decode in cycle N+2.
// Backpressure: decode stall holds the head; issue stops once outstanding + buffered reaches DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic [31:0] fetch_pc;
    cnt_t        outstanding;
    cnt_t        drop;
    cnt_t        count;
    ptr_t        aq_rd;
    ptr_t        aq_wr;
    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    logic [31:0] aq_mem [DEPTH];
    entry_t      buf_mem [DEPTH];

    logic        credit_ok;
    logic        req_fire;
    logic        resp_drop;
    logic        buf_push;
    logic        buf_pop;
    logic [1:0]  unused_pc_bits;

    assign unused_pc_bits = redirect_pc[1:0];

    // Credits cover both in-flight requests and buffered words, so a response always has a slot.
    assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign resp_drop = imem_resp_valid & (drop != '0);
    assign buf_push  = imem_resp_valid & (drop == '0) & ~redirect_valid;
    assign buf_pop   = inst_valid & inst_ready & ~redirect_valid;

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? buf_mem[rd_ptr].word : NOP;
    assign inst_pc    = inst_valid ? buf_mem[rd_ptr].pc   : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(imem_resp_valid);
            aq_wr       <= aq_wr + ptr_t'(req_fire);
            aq_rd       <= aq_rd + ptr_t'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                // Everything still in flight after this cycle belongs to the old path.
                drop     <= outstanding - cnt_t'(imem_resp_valid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop) begin
                    drop <= drop - cnt_t'(1);
                end
                wr_ptr <= wr_ptr + ptr_t'(buf_push);
                rd_ptr <= rd_ptr + ptr_t'(buf_pop);
                count  <= count + cnt_t'(buf_push) - cnt_t'(buf_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_mem[aq_wr] <= fetch_pc;
        end
        if (buf_push) begin
            buf_mem[wr_ptr] <= '{pc: aq_mem[aq_rd], word: imem_resp_data};
        end
    end

endmodule
